// File: rtl/bus16bit_pkg.sv
// rtl/bus16bit_pkg.sv - shared constants and types for the bus16bit distributor
package bus16bit_pkg;

  localparam int NCH = 4;
  localparam int W   = 16;

  typedef logic [1:0] sel_t;

  function automatic int occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bus16bit_dist_fifo.sv
// rtl/bus16bit_dist_fifo.sv - per-channel FIFO with occupancy count
module dist_fifo
  import bus16bit_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [occ_w(DEPTH)-1:0]  occ
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = occ_w(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [OW-1:0] r_occ;
  logic          w_do_push;
  logic          w_do_pop;

  assign full      = (r_occ == OW'(DEPTH));
  assign empty     = (r_occ == '0);
  assign occ       = r_occ;
  assign dout      = r_mem[r_rptr];
  // A full FIFO refuses a push even when popped in the same cycle.
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= din;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_do_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_occ <= r_occ + OW'(1);
        2'b01:   r_occ <= r_occ - OW'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: rtl/bus16bit_dist.sv
// rtl/bus16bit_dist.sv - distributes bus words to four FIFO-buffered channels
module bus16bit_dist
  import bus16bit_pkg::*;
#(
  parameter int W     = bus16bit_pkg::W,
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [W-1:0]                  i,
  input  sel_t                          s,
  input  logic                          iv,
  output logic                          ir,
  output logic [W-1:0]                  o0,
  output logic [W-1:0]                  o1,
  output logic [W-1:0]                  o2,
  output logic [W-1:0]                  o3,
  output logic [NCH-1:0]                ov,
  input  logic [NCH-1:0]                ordy,
  output logic [NCH*occ_w(DEPTH)-1:0]   occ,
  output logic [NCH-1:0]                ovf
);

  localparam int OW = occ_w(DEPTH);

  logic [NCH-1:0] w_full;
  logic [NCH-1:0] w_empty;
  logic [NCH-1:0] w_push;
  logic [NCH-1:0] w_pop;
  logic [W-1:0]   w_dout [NCH];
  logic [OW-1:0]  w_occ  [NCH];
  logic [NCH-1:0] r_ovf;

  // Ready depends only on the selected channel's fill state, never on ordy.
  assign ir = !w_full[s];

  genvar k;
  generate
    for (k = 0; k < NCH; k++) begin : g_ch
      assign w_push[k] = iv && ir && (s == sel_t'(k));
      assign w_pop[k]  = ordy[k] && !w_empty[k];
      assign ov[k]     = !w_empty[k];
      assign occ[k*OW +: OW] = w_occ[k];

      dist_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push[k]),
        .pop   (w_pop[k]),
        .din   (i),
        .dout  (w_dout[k]),
        .full  (w_full[k]),
        .empty (w_empty[k]),
        .occ   (w_occ[k])
      );
    end
  endgenerate

  assign o0  = w_dout[0];
  assign o1  = w_dout[1];
  assign o2  = w_dout[2];
  assign o3  = w_dout[3];
  assign ovf = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= '0;
    end else if (iv && w_full[s]) begin
      r_ovf[s] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bus16bit_dist.sv
// tb/tb_bus16bit_dist.sv - directed self-checking bench for bus16bit_dist
module tb_bus16bit_dist;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] i;
  logic [1:0]  s;
  logic        iv;
  logic        ir;
  logic [15:0] o0, o1, o2, o3;
  logic [3:0]  ov;
  logic [3:0]  ordy;
  logic [7:0]  occ;
  logic [3:0]  ovf;
  logic [15:0] w_o [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign w_o[0] = o0;
  assign w_o[1] = o1;
  assign w_o[2] = o2;
  assign w_o[3] = o3;

  bus16bit_dist #(.W(16), .DEPTH(2)) dut (
    .clk  (clk),
    .rst  (rst),
    .i    (i),
    .s    (s),
    .iv   (iv),
    .ir   (ir),
    .o0   (o0),
    .o1   (o1),
    .o2   (o2),
    .o3   (o3),
    .ov   (ov),
    .ordy (ordy),
    .occ  (occ),
    .ovf  (ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; iv = 1'b0; ordy = 4'b0000; i = '0; s = '0;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (ov !== 4'b0000) begin n_fail++; $display("FAIL reset_ov: got %b expected %b", ov, 4'b0000); end
    n_checks++; if (ir !== 1'b1) begin n_fail++; $display("FAIL reset_ir: got %b expected %b", ir, 1'b1); end
    n_checks++; if (occ !== 8'h00) begin n_fail++; $display("FAIL reset_occ: got %h expected %h", occ, 8'h00); end
    n_checks++; if (ovf !== 4'b0000) begin n_fail++; $display("FAIL reset_ovf: got %b expected %b", ovf, 4'b0000); end
    n_checks++; if ({o0, o1, o2, o3} !== 64'h0) begin n_fail++; $display("FAIL reset_o: got %h expected %h", {o0, o1, o2, o3}, 64'h0); end
  endtask

  task automatic test_single_push();
    i = 16'hA5A5; s = 2'd2; iv = 1'b1; ordy = 4'b0000;
    step();
    iv = 1'b0;
    n_checks++; if (ov !== 4'b0100) begin n_fail++; $display("FAIL single_ov: got %b expected %b", ov, 4'b0100); end
    n_checks++; if (o2 !== 16'hA5A5) begin n_fail++; $display("FAIL single_o2: got %h expected %h", o2, 16'hA5A5); end
    n_checks++; if (occ !== 8'h10) begin n_fail++; $display("FAIL single_occ: got %h expected %h", occ, 8'h10); end
    n_checks++; if (ovf !== 4'b0000) begin n_fail++; $display("FAIL single_ovf: got %b expected %b", ovf, 4'b0000); end
  endtask

  task automatic test_overflow();
    s = 2'd1; iv = 1'b1; ordy = 4'b0000;
    i = 16'h0001; step();
    i = 16'h0002; step();
    i = 16'h0003; #1;
    n_checks++; if (ir !== 1'b0) begin n_fail++; $display("FAIL ovf_ir_low: got %b expected %b", ir, 1'b0); end
    step();
    iv = 1'b0;
    n_checks++; if (ovf !== 4'b0010) begin n_fail++; $display("FAIL ovf_flag: got %b expected %b", ovf, 4'b0010); end
    n_checks++; if (occ !== 8'h18) begin n_fail++; $display("FAIL ovf_occ: got %h expected %h", occ, 8'h18); end
    n_checks++; if (o1 !== 16'h0001) begin n_fail++; $display("FAIL ovf_head0: got %h expected %h", o1, 16'h0001); end
    ordy = 4'b0010;
    step();
    n_checks++; if (o1 !== 16'h0002) begin n_fail++; $display("FAIL ovf_head1: got %h expected %h", o1, 16'h0002); end
    step();
    ordy = 4'b0000;
    n_checks++; if (ov[1] !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got %b expected %b", ov[1], 1'b0); end
  endtask

  task automatic test_full_pop();
    s = 2'd1; iv = 1'b1; ordy = 4'b0000;
    i = 16'h0011; step();
    i = 16'h0012; step();
    i = 16'h0013; ordy = 4'b0010; #1;
    n_checks++; if (ir !== 1'b0) begin n_fail++; $display("FAIL fullpop_ir_low: got %b expected %b", ir, 1'b0); end
    step();
    ordy = 4'b0000;
    n_checks++; if (ir !== 1'b1) begin n_fail++; $display("FAIL fullpop_ir_high: got %b expected %b", ir, 1'b1); end
    n_checks++; if (occ[3:2] !== 2'd1) begin n_fail++; $display("FAIL fullpop_occ1: got %0d expected %0d", occ[3:2], 1); end
    n_checks++; if (o1 !== 16'h0012) begin n_fail++; $display("FAIL fullpop_head: got %h expected %h", o1, 16'h0012); end
    step();
    iv = 1'b0;
    n_checks++; if (occ[3:2] !== 2'd2) begin n_fail++; $display("FAIL fullpop_accept: got %0d expected %0d", occ[3:2], 2); end
    ordy = 4'b0010;
    step();
    n_checks++; if (o1 !== 16'h0013) begin n_fail++; $display("FAIL fullpop_held_word: got %h expected %h", o1, 16'h0013); end
    ordy = 4'b0110;
    step();
    ordy = 4'b0000;
    n_checks++; if (ov !== 4'b0000) begin n_fail++; $display("FAIL fullpop_all_empty: got %b expected %b", ov, 4'b0000); end
    n_checks++; if (occ !== 8'h00) begin n_fail++; $display("FAIL fullpop_occ_zero: got %h expected %h", occ, 8'h00); end
  endtask

  task automatic test_round_robin();
    do_reset();
    ordy = 4'b1111; iv = 1'b1;
    for (int j = 0; j < 8; j++) begin
      i = 16'h0010 + 16'(j);
      s = 2'(j % 4);
      step();
      n_checks++; if (w_o[j % 4] !== 16'h0010 + 16'(j)) begin n_fail++; $display("FAIL rr_data[%0d]: got %h expected %h", j, w_o[j % 4], 16'h0010 + 16'(j)); end
      n_checks++; if (ov !== 4'(1 << (j % 4))) begin n_fail++; $display("FAIL rr_ov[%0d]: got %b expected %b", j, ov, 4'(1 << (j % 4))); end
    end
    iv = 1'b0;
    step();
    ordy = 4'b0000;
    n_checks++; if (ov !== 4'b0000) begin n_fail++; $display("FAIL rr_drained: got %b expected %b", ov, 4'b0000); end
    n_checks++; if (ovf !== 4'b0000) begin n_fail++; $display("FAIL rr_ovf: got %b expected %b", ovf, 4'b0000); end
  endtask

  task automatic test_async_reset();
    s = 2'd3; iv = 1'b1; ordy = 4'b0000;
    i = 16'h0031; step();
    i = 16'h0032; step();
    i = 16'h0033; step();
    iv = 1'b0;
    n_checks++; if (ovf !== 4'b1000) begin n_fail++; $display("FAIL arst_pre_ovf: got %b expected %b", ovf, 4'b1000); end
    n_checks++; if (occ !== 8'h80) begin n_fail++; $display("FAIL arst_pre_occ: got %h expected %h", occ, 8'h80); end
    #3;
    rst = 1'b1;
    #1;
    n_checks++; if (ov !== 4'b0000) begin n_fail++; $display("FAIL arst_ov: got %b expected %b", ov, 4'b0000); end
    n_checks++; if (occ !== 8'h00) begin n_fail++; $display("FAIL arst_occ: got %h expected %h", occ, 8'h00); end
    n_checks++; if (ovf !== 4'b0000) begin n_fail++; $display("FAIL arst_ovf: got %b expected %b", ovf, 4'b0000); end
    #1;
    rst = 1'b0;
    i = 16'hBEEF; s = 2'd3; iv = 1'b1;
    step();
    iv = 1'b0;
    n_checks++; if (o3 !== 16'hBEEF) begin n_fail++; $display("FAIL arst_post_o3: got %h expected %h", o3, 16'hBEEF); end
    n_checks++; if (occ !== 8'h40) begin n_fail++; $display("FAIL arst_post_occ: got %h expected %h", occ, 8'h40); end
    n_checks++; if (ov !== 4'b1000) begin n_fail++; $display("FAIL arst_post_ov: got %b expected %b", ov, 4'b1000); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; iv = 1'b0; ordy = 4'b0000; i = '0; s = '0;
    test_reset();
    test_single_push();
    test_overflow();
    test_full_pop();
    test_round_robin();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
